// File: rtl/quad_dec_cpu_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// quad_dec_cpu_ocimem_ctrl
//
// Sysclk-side debug memory access engine. Turns JTAG host commands (jdo word
// plus ocimem take-action strobes) into single-cycle read/write accesses on an
// external debug RAM port, with an auto-incrementing address register.
//
// Ports:
//   clk, reset_n              system clock, async active-low reset
//   jdo[37:0]                 JTAG data word (stable while a strobe is high)
//   take_action_ocimem_a      address-load / load-and-read command
//   take_no_action_ocimem_a   streaming read at the current address
//   take_action_ocimem_b      write command (data in jdo[34:3])
//   ram_rdata                 debug RAM read data
//   ram_addr/ram_rd/ram_wr/ram_wdata   debug RAM access port
//   MonDReg                   read result or last write data
//   MonAReg                   current access address
//   mon_busy                  access in progress (high in every non-IDLE state)
//   mon_overrun               sticky: a command was dropped
// ---------------------------------------------------------------------------
module quad_dec_cpu_ocimem_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [31:0]       ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              mon_busy,
    output logic              mon_overrun
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_CAP   = 3'd3,
        WR_ISSUE = 3'd4
    } state_t;

    state_t state;
    logic [1:0] wait_cnt;

    // jdo field decode
    logic              addr_load;
    logic              rd_req;
    logic [ADDR_W-1:0] jaddr;
    logic [31:0]       jwdata;
    logic              unused_jdo;

    assign addr_load  = jdo[35];
    assign rd_req     = jdo[34];
    assign jaddr      = jdo[26 +: ADDR_W];
    assign jwdata     = jdo[34:3];
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // The RAM port always shows the current access address and data register.
    assign ram_addr  = MonAReg;
    assign ram_wdata = MonDReg;

    // Arbitration: a > no_action_a > b, and nothing is taken unless IDLE.
    logic idle, acc_a, acc_na, acc_b, drop, start_rd;

    always_comb begin
        idle     = (state == IDLE);
        acc_a    = idle & take_action_ocimem_a;
        acc_na   = idle & take_no_action_ocimem_a & ~take_action_ocimem_a;
        acc_b    = idle & take_action_ocimem_b & ~take_action_ocimem_a
                        & ~take_no_action_ocimem_a;
        drop     = (take_action_ocimem_a    & ~acc_a)
                 | (take_no_action_ocimem_a & ~acc_na)
                 | (take_action_ocimem_b    & ~acc_b);
        start_rd = (acc_a & rd_req) | acc_na;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= 2'd0;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
            MonDReg     <= 32'd0;
            MonAReg     <= '0;
            mon_busy    <= 1'b0;
            mon_overrun <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;

            // A dropped strobe in the same cycle as an accepted load still
            // leaves the flag set: set dominates clear.
            if (drop)
                mon_overrun <= 1'b1;
            else if (acc_a & addr_load)
                mon_overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (acc_a & addr_load)
                        MonAReg <= jaddr;
                    if (start_rd) begin
                        state    <= RD_ISSUE;
                        ram_rd   <= 1'b1;
                        mon_busy <= 1'b1;
                    end else if (acc_b) begin
                        state    <= WR_ISSUE;
                        ram_wr   <= 1'b1;
                        mon_busy <= 1'b1;
                        MonDReg  <= jwdata;
                    end
                end
                RD_ISSUE: begin
                    if (READ_LATENCY > 1) begin
                        state    <= RD_WAIT;
                        wait_cnt <= 2'(READ_LATENCY - 2);
                    end else begin
                        state <= RD_CAP;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 2'd0)
                        state <= RD_CAP;
                    else
                        wait_cnt <= wait_cnt - 2'd1;
                end
                RD_CAP: begin
                    MonDReg  <= ram_rdata;
                    MonAReg  <= MonAReg + ADDR_W'(1);
                    state    <= IDLE;
                    mon_busy <= 1'b0;
                end
                WR_ISSUE: begin
                    MonAReg  <= MonAReg + ADDR_W'(1);
                    state    <= IDLE;
                    mon_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mon_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_dec_cpu_ocimem_ctrl.sv
// Two instances share one stimulus stream: READ_LATENCY=1 (index 0) and
// READ_LATENCY=3 (index 1). Each has its own RAM and its own command-level
// reference model.
module tb_quad_dec_cpu_ocimem_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic [37:0] jdo;
    logic sa, sna, sb;
    logic load_mem;

    logic [1:0][31:0] ram_rdata;
    logic [1:0][7:0]  ram_addr;
    logic [1:0]       ram_rd, ram_wr;
    logic [1:0][31:0] ram_wdata;
    logic [1:0][31:0] MonDReg;
    logic [1:0][7:0]  MonAReg;
    logic [1:0]       mon_busy, mon_overrun;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        quad_dec_cpu_ocimem_ctrl #(
            .ADDR_W(8),
            .READ_LATENCY((g == 0) ? 1 : 3)
        ) dut (
            .clk                    (clk),
            .reset_n                (reset_n),
            .jdo                    (jdo),
            .take_action_ocimem_a   (sa),
            .take_no_action_ocimem_a(sna),
            .take_action_ocimem_b   (sb),
            .ram_rdata              (ram_rdata[g]),
            .ram_addr               (ram_addr[g]),
            .ram_rd                 (ram_rd[g]),
            .ram_wr                 (ram_wr[g]),
            .ram_wdata              (ram_wdata[g]),
            .MonDReg                (MonDReg[g]),
            .MonAReg                (MonAReg[g]),
            .mon_busy               (mon_busy[g]),
            .mon_overrun            (mon_overrun[g])
        );
    end

    // ---------------- debug RAM environment ----------------
    logic [31:0] seed;
    logic [31:0] env_mem [2][256];
    logic [2:0]  pv [2];
    logic [31:0] pd [2][3];
    logic [31:0] junk;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B9) ^ seed;
    endfunction

    always @(posedge clk) begin
        junk <= $urandom;
        for (int d = 0; d < 2; d++) begin
            if (load_mem) begin
                for (int i = 0; i < 256; i++) env_mem[d][i] <= init_word(i);
            end else if (ram_wr[d]) begin
                env_mem[d][ram_addr[d]] <= ram_wdata[d];
            end
            pv[d][0] <= ram_rd[d];
            pd[d][0] <= env_mem[d][ram_addr[d]];
            pv[d][1] <= pv[d][0];
            pd[d][1] <= pd[d][0];
            pv[d][2] <= pv[d][1];
            pd[d][2] <= pd[d][1];
        end
    end

    // Data is only valid exactly READ_LATENCY clocks after the read; other
    // cycles carry garbage so a mistimed capture shows up.
    assign ram_rdata[0] = pv[0][0] ? pd[0][0] : junk;
    assign ram_rdata[1] = pv[1][2] ? pd[1][2] : junk;

    // ---------------- checking helpers ----------------
    task automatic chk(input int d, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input int d);
        chk(d, "rst_ram_addr", 32'(ram_addr[d]), 32'd0);
        chk(d, "rst_ram_rd", 32'(ram_rd[d]), 32'd0);
        chk(d, "rst_ram_wr", 32'(ram_wr[d]), 32'd0);
        chk(d, "rst_ram_wdata", ram_wdata[d], 32'd0);
        chk(d, "rst_MonDReg", MonDReg[d], 32'd0);
        chk(d, "rst_MonAReg", 32'(MonAReg[d]), 32'd0);
        chk(d, "rst_mon_busy", 32'(mon_busy[d]), 32'd0);
        chk(d, "rst_mon_overrun", 32'(mon_overrun[d]), 32'd0);
    endtask

    // ---------------- command-level reference model ----------------
    // Each accepted command is reduced to: a busy window length, the one-cycle
    // RAM strobe it causes, and the register values when the window closes.
    logic [7:0]  m_a [2];
    logic [31:0] m_d [2];
    logic        m_ovr [2];
    int          m_busy [2];
    logic        m_pend_rd [2];
    logic [31:0] m_pend_val [2];
    logic        m_rd [2];
    logic        m_wr [2];
    logic [31:0] shadow [2][256];

    task automatic start_read(input int d, input int lat);
        m_rd[d]       = 1'b1;
        m_busy[d]     = lat + 1;
        m_pend_rd[d]  = 1'b1;
        m_pend_val[d] = shadow[d][m_a[d]];
    endtask

    task automatic model_step(input int d);
        int lat;
        lat = (d == 0) ? 1 : 3;
        m_rd[d] = 1'b0;
        m_wr[d] = 1'b0;
        if (!reset_n) begin
            m_a[d] = 8'd0; m_d[d] = 32'd0; m_ovr[d] = 1'b0;
            m_busy[d] = 0; m_pend_rd[d] = 1'b0;
            return;
        end
        if (m_busy[d] > 0) begin
            if (sa || sna || sb) m_ovr[d] = 1'b1;
            m_busy[d]--;
            if (m_busy[d] == 0) begin
                if (m_pend_rd[d]) m_d[d] = m_pend_val[d];
                m_a[d] = m_a[d] + 8'd1;
            end
        end else if (sa) begin
            if (jdo[35]) begin
                m_a[d]   = jdo[33:26];
                m_ovr[d] = 1'b0;
            end
            if (sna || sb) m_ovr[d] = 1'b1;
            if (jdo[34]) start_read(d, lat);
        end else if (sna) begin
            if (sb) m_ovr[d] = 1'b1;
            start_read(d, lat);
        end else if (sb) begin
            m_d[d]             = jdo[34:3];
            shadow[d][m_a[d]]  = m_d[d];
            m_wr[d]            = 1'b1;
            m_busy[d]          = 1;
            m_pend_rd[d]       = 1'b0;
        end
    endtask

    // Model advances on each rising edge; outputs compared on the falling edge.
    initial begin
        seed = $urandom;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) shadow[d][i] = init_word(i);
            m_a[d] = 8'd0; m_d[d] = 32'd0; m_ovr[d] = 1'b0; m_busy[d] = 0;
            m_pend_rd[d] = 1'b0; m_pend_val[d] = 32'd0; m_rd[d] = 1'b0; m_wr[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_step(d);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk(d, "ram_rd", 32'(ram_rd[d]), 32'(m_rd[d]));
                chk(d, "ram_wr", 32'(ram_wr[d]), 32'(m_wr[d]));
                chk(d, "ram_addr", 32'(ram_addr[d]), 32'(m_a[d]));
                chk(d, "MonDReg", MonDReg[d], m_d[d]);
                chk(d, "MonAReg", 32'(MonAReg[d]), 32'(m_a[d]));
                chk(d, "mon_busy", 32'(mon_busy[d]), 32'(m_busy[d] > 0));
                chk(d, "mon_overrun", 32'(mon_overrun[d]), 32'(m_ovr[d]));
                if (m_wr[d]) chk(d, "ram_wdata", ram_wdata[d], m_d[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [37:0] cmd_a(input logic ld, input logic rd, input logic [7:0] ad);
        return {2'b00, ld, rd, ad, 26'h0};
    endfunction

    function automatic logic [37:0] cmd_w(input logic [31:0] w);
        return {3'b000, w, 3'b000};
    endfunction

    // Strobe sampled on the next rising edge; returns on the falling edge after it.
    task automatic send(input logic a, input logic na, input logic b, input logic [37:0] j);
        @(negedge clk);
        sa = a; sna = na; sb = b; jdo = j;
        @(negedge clk);
        sa = 1'b0; sna = 1'b0; sb = 1'b0;
        jdo = {6'($urandom), 32'($urandom)};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (mon_busy != 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk(0, "idle_timeout", 32'(mon_busy), 32'd0);
    endtask

    initial begin
        int r;
        reset_n = 1'b0; sa = 1'b0; sna = 1'b0; sb = 1'b0; jdo = '0; load_mem = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk_zero(d);
        @(negedge clk);
        load_mem = 1'b0;
        reset_n  = 1'b1;

        // Load 0x10, write DEADBEEF there, then load-and-read it back.
        send(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b0, 8'h10));
        wait_idle();
        send(1'b0, 1'b0, 1'b1, cmd_w(32'hDEADBEEF));
        wait_idle();
        send(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b1, 8'h10));
        chk(0, "lr_ram_rd", 32'(ram_rd[0]), 32'd1);
        chk(0, "lr_ram_addr", 32'(ram_addr[0]), 32'h10);
        chk(0, "lr_busy1", 32'(mon_busy[0]), 32'd1);
        @(negedge clk);
        chk(0, "lr_ram_rd_off", 32'(ram_rd[0]), 32'd0);
        chk(0, "lr_busy2", 32'(mon_busy[0]), 32'd1);
        @(negedge clk);
        chk(0, "lr_MonDReg", MonDReg[0], 32'hDEADBEEF);
        chk(0, "lr_MonAReg", 32'(MonAReg[0]), 32'h11);
        chk(0, "lr_busy_end", 32'(mon_busy[0]), 32'd0);
        wait_idle();

        // Streaming read at 0x05 on the 3-cycle RAM: capture 4 clocks after strobe.
        send(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b0, 8'h05));
        wait_idle();
        send(1'b0, 1'b1, 1'b0, cmd_a(1'b0, 1'b0, 8'h00));
        chk(1, "sr_ram_rd", 32'(ram_rd[1]), 32'd1);
        @(negedge clk);
        chk(1, "sr_ram_rd_off", 32'(ram_rd[1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk(1, "sr_MonDReg_early", MonDReg[1], 32'hDEADBEEF);
        @(negedge clk);
        chk(1, "sr_MonDReg", MonDReg[1], init_word(5));
        chk(1, "sr_MonAReg", 32'(MonAReg[1]), 32'h06);
        wait_idle();

        // Write stream across the address wrap.
        send(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b0, 8'hFF));
        wait_idle();
        send(1'b0, 1'b0, 1'b1, cmd_w(32'h12345678));
        wait_idle();
        send(1'b0, 1'b0, 1'b1, cmd_w(32'hCAFEF00D));
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            chk(d, "wr_mem_ff", env_mem[d][255], 32'h12345678);
            chk(d, "wr_mem_00", env_mem[d][0], 32'hCAFEF00D);
            chk(d, "wr_MonAReg", 32'(MonAReg[d]), 32'h01);
            chk(d, "wr_MonDReg", MonDReg[d], 32'hCAFEF00D);
        end

        // Collision a+b: load wins, write dropped, overrun set.
        send(1'b1, 1'b0, 1'b1, cmd_a(1'b1, 1'b0, 8'h20));
        for (int d = 0; d < 2; d++) begin
            chk(d, "col_ram_wr", 32'(ram_wr[d]), 32'd0);
            chk(d, "col_ovr", 32'(mon_overrun[d]), 32'd1);
            chk(d, "col_MonAReg", 32'(MonAReg[d]), 32'h20);
        end
        send(1'b0, 1'b1, 1'b0, cmd_a(1'b0, 1'b0, 8'h00));
        send(1'b0, 1'b1, 1'b0, cmd_a(1'b0, 1'b0, 8'h00));
        wait_idle();
        for (int d = 0; d < 2; d++) chk(d, "col_ovr_stays", 32'(mon_overrun[d]), 32'd1);
        send(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b0, 8'h30));
        for (int d = 0; d < 2; d++) chk(d, "col_ovr_clr", 32'(mon_overrun[d]), 32'd0);
        // Write arriving while a read is in flight is dropped.
        send(1'b0, 1'b1, 1'b0, cmd_a(1'b0, 1'b0, 8'h00));
        send(1'b0, 1'b0, 1'b1, cmd_w(32'h0BADF00D));
        for (int d = 0; d < 2; d++) chk(d, "busy_drop_ovr", 32'(mon_overrun[d]), 32'd1);
        wait_idle();

        // Reset in the middle of a read (index 1 sits in its wait phase).
        send(1'b0, 1'b1, 1'b0, cmd_a(1'b0, 1'b0, 8'h00));
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk_zero(d);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk(1, "postrst_MonDReg", MonDReg[1], 32'd0);
        chk(1, "postrst_MonAReg", 32'(MonAReg[1]), 32'd0);
        send(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b1, 8'h07));
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            chk(d, "postrst_rd", MonDReg[d], init_word(7));
            chk(d, "postrst_addr", 32'(MonAReg[d]), 32'h08);
        end

        // Random traffic, including coincident and busy-time strobes.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            r   = $urandom_range(0, 99);
            sa  = (r < 8);
            sna = (r >= 5 && r < 15);
            sb  = (r >= 12 && r < 26);
            jdo = {6'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) jdo[33:26] = 8'hFF;
        end
        @(negedge clk);
        sa = 1'b0; sna = 1'b0; sb = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                chk(d, "final_mem", env_mem[d][i], shadow[d][i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/quad_dec_cpu_ocimem_ctrl.md
Name: quad_dec_cpu_ocimem_ctrl

Overview:
Sysclk-domain debug memory access engine. It sits directly downstream of the JTAG debug module's sysclk stage and consumes its jdo word and ocimem take-action strobes. It turns those host commands into single-cycle read/write accesses on an external debug RAM port, with an auto-incrementing address register. Read results land in MonDReg, which the JTAG tck stage shifts back out to the host.

Parameters:
ADDR_W, 8, debug RAM word-address width; legal range 1..8.
READ_LATENCY, 1, clocks from ram_rd asserted to ram_rdata valid; legal range 1..3.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data word from the sysclk stage; stable while any strobe is high
take_action_ocimem_a  in  1  1-cycle strobe: address-load command
take_no_action_ocimem_a  in  1  1-cycle strobe: streaming read at current address
take_action_ocimem_b  in  1  1-cycle strobe: write command
ram_rdata  in  32  debug RAM read data
ram_addr  out  ADDR_W  debug RAM address
ram_rd  out  1  debug RAM read enable
ram_wr  out  1  debug RAM write enable
ram_wdata  out  32  debug RAM write data
MonDReg  out  32  monitor data register (read result or last write data)
MonAReg  out  ADDR_W  current access address
mon_busy  out  1  access in progress
mon_overrun  out  1  sticky: a command was dropped

Behaviour:
- Reset: async, active-low. All outputs 0. FSM goes to IDLE. A reset mid-access aborts the access with no RAM strobe after reset.
- jdo decode:
  - jdo[35] = addr_load
  - jdo[34] = rd_req (valid with strobe a only)
  - jdo[26+ADDR_W-1:26] = address
  - jdo[34:3] = write data (valid with strobe b)
- Command rules:
  - take_action_ocimem_a: if addr_load, MonAReg <= address and mon_overrun <= 0. If rd_req, start a read at the newly loaded address.
  - take_no_action_ocimem_a: start a read at MonAReg.
  - take_action_ocimem_b: MonDReg <= jdo[34:3] in the strobe cycle; start a write.
- Priority when strobes coincide in one cycle: a > no_action_a > b. Each losing strobe sets mon_overrun.
- Any strobe arriving while mon_busy=1 is dropped and sets mon_overrun. An address load is also dropped if busy.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_CAP, WR_ISSUE.
  - IDLE -> RD_ISSUE or WR_ISSUE on an accepted command (the cycle after the strobe).
  - RD_ISSUE: ram_rd=1 and ram_addr=MonAReg for exactly 1 cycle. Next state is RD_WAIT if READ_LATENCY>1, else RD_CAP.
  - RD_WAIT: counts READ_LATENCY-1 cycles, ram_rd=0.
  - RD_CAP: MonDReg <= ram_rdata; MonAReg <= MonAReg+1; -> IDLE.
  - WR_ISSUE: ram_wr=1, ram_addr=MonAReg, ram_wdata=MonDReg for 1 cycle; MonAReg <= MonAReg+1; -> IDLE.
- mon_busy is high in every non-IDLE state (registered from state). It is low in the strobe cycle itself.
- Latency:
  - Read: MonDReg updates READ_LATENCY+1 clocks after the strobe edge.
  - Write: ram_wr asserts 1 clock after the strobe.
  - The next command is accepted on the first cycle mon_busy=0.
- Address increment wraps modulo 2^ADDR_W (all-ones -> 0) with no flag.
- ram_rd and ram_wr are never high together. ram_addr holds MonAReg in all states.
- mon_overrun is cleared only by an accepted address load or by reset.

Test Plan:
- Address load then read: strobe a with jdo[35]=1, jdo[34]=1, addr=0x10; RAM[0x10]=0xDEADBEEF, READ_LATENCY=1 -> ram_rd high 1 cycle with ram_addr=0x10; MonDReg=0xDEADBEEF 2 clocks after strobe; MonAReg=0x11; mon_busy high exactly 2 cycles.
- Streaming write with wrap: load addr 0xFF; write 0x12345678, then 0xCAFEF00D -> RAM[0xFF]=0x12345678, RAM[0x00]=0xCAFEF00D; MonAReg=0x01; MonDReg=0xCAFEF00D.
- Latency param: READ_LATENCY=3, streaming read at addr 0x05 -> MonDReg captured exactly 4 clocks after strobe; ram_rd pulse width 1 cycle.
- Collision: strobe a and strobe b in the same cycle -> address load wins, no ram_wr, mon_overrun=1. A later strobe while busy is dropped and the flag stays 1. The next accepted address load clears it to 0.
- Reset mid-read: assert reset_n=0 during RD_WAIT (READ_LATENCY=3) -> all outputs 0 immediately. After release: no ram_rd, no MonDReg update, and IDLE accepts the next command.
